eltwise_stream_ctrl: RTL and testbench
======================================

Name: eltwise_stream_ctrl

Overview:
Sequencer for one elementwise streaming pass (ReLU or similar fixed-latency unit) between two global SRAM buffers. On start it reads len words from the source buffer at src_base, streams them into the elementwise unit, and writes results to the destination buffer at dst_base. The destination port is shared, so writes are grant-gated and results are buffered in an internal skid FIFO. A credit counter bounds outstanding words so that FIFO can never overflow.

Parameters:
ADDR_W, 10, word-address width of both buffers and of len
DATA_W, 16, data word width
MAX_INFLIGHT, 4, maximum words issued but not yet written; also the output FIFO depth (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
start  input  1  job request, sampled only in IDLE
src_base  input  ADDR_W  source start address, captured on accepted start
dst_base  input  ADDR_W  destination start address, captured on accepted start
len  input  ADDR_W  word count, captured on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at job end
err_busy  output  1  one-cycle pulse when start is seen while not IDLE
src_ren  output  1  source read strobe
src_addr  output  ADDR_W  source read address
src_rdata  input  DATA_W  source data, valid the cycle after src_ren
pe_in_valid  output  1  elementwise unit input valid
pe_in_data  output  DATA_W  equals src_rdata (combinational pass-through)
pe_out_valid  input  1  elementwise unit result valid (no backpressure)
pe_out_data  input  DATA_W  elementwise unit result
dst_req  output  1  high while the FIFO is non-empty
dst_gnt  input  1  arbiter grant for the destination port
dst_wen  output  1  dst_req & dst_gnt
dst_addr  output  ADDR_W  dst_base + wr_cnt
dst_wdata  output  DATA_W  FIFO head

Behaviour:
- Reset: state IDLE; all counters, FIFO pointers, and the pe_in_valid register cleared. busy, done, err_busy, src_ren, pe_in_valid, dst_req, and dst_wen are 0. Reset mid-job abandons the job; no done pulse is produced.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: on start, capture bases and len and clear issue_cnt, wr_cnt, and inflight. Go to FIN if len==0 (no memory accesses), else go to RUN.
- RUN: issue = (issue_cnt < len) & (inflight < MAX_INFLIGHT). src_ren = issue and src_addr = src_base + issue_cnt, both combinational. On issue, issue_cnt is incremented. The cycle of the last issue (issue_cnt == len-1) moves the state to DRAIN.
- DRAIN: no issues. Move to FIN in the cycle of the last write fire (wr_cnt == len-1 & dst_wen).
- FIN: done=1 and busy=0 for one cycle, then IDLE. busy=1 in RUN and DRAIN only.
- pe_in_valid is src_ren registered by one cycle.
- pe_out_valid pushes pe_out_data into the FIFO unconditionally. A write fire (dst_wen) pops the FIFO and increments wr_cnt.
- inflight is +1 on issue and -1 on write fire; with both in the same cycle it is unchanged. Invariant: inflight <= MAX_INFLIGHT, hence the FIFO never overflows. A push to a full FIFO is a design error; the bench asserts it never happens.
- A push and a pop in the same cycle are legal, including when the FIFO is full (pop first) or empty (the pushed data appears at the head next cycle, not the same cycle).
- Address arithmetic is modulo 2^ADDR_W, so src_base + len may wrap past the top of the buffer to 0.
- pe_out_valid seen outside RUN/DRAIN is ignored (not pushed).
- start while busy or in FIN produces an err_busy pulse; the job is otherwise unaffected.
- Throughput: 1 word/cycle when dst_gnt is held high and MAX_INFLIGHT >= PE latency + 3.

Test Plan:
- Basic job: src_base=0x010, dst_base=0x200, len=4, PE latency 1, dst_gnt=1, start sampled at edge 0 -> src_ren in cycles 1-4 (addresses 0x010-0x013); dst_wen in cycles 4-7 (addresses 0x200-0x203); done in cycle 8; busy high in cycles 1-7.
- Zero length: len=0 -> done one cycle after start; no src_ren or dst_wen; busy stays 0.
- Grant stall: len=8, dst_gnt=0 until cycle 20 -> exactly 4 src_ren, then src_ren stays 0; FIFO reaches 4 entries with no overflow. After the grant, all 8 words are written in order and done fires once.
- Wrap-around: src_base=0x3FE, dst_base=0x3FF, len=3 -> src addresses 0x3FE, 0x3FF, 0x000; dst addresses 0x3FF, 0x000, 0x001.
- Random dst_gnt (50%), len=1023, PE latency 3 -> written data equals the PE results in address order; inflight never exceeds 4; exactly one done pulse.
- Error and reset: start pulsed mid-job -> err_busy pulse and the job completes unchanged. Reset asserted mid-DRAIN -> all outputs 0 and no done pulse; a fresh job with len=2 afterwards completes correctly.

Source files
------------

// File: rtl/eltwise_stream_ctrl.sv
// Sequencer for one elementwise streaming pass: source SRAM -> PE -> skid FIFO -> shared destination port.
// A credit counter caps the words in flight at the FIFO depth, so the FIFO cannot overflow.
module eltwise_stream_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err_busy,
    output logic              src_ren,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_rdata,
    output logic              pe_in_valid,
    output logic [DATA_W-1:0] pe_in_data,
    input  logic              pe_out_valid,
    input  logic [DATA_W-1:0] pe_out_data,
    output logic              dst_req,
    input  logic              dst_gnt,
    output logic              dst_wen,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_wdata
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | issuing source reads, writing results as granted
    // DRAIN | all reads issued, waiting for the last write
    // FIN   | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_base_q, dst_base_q, len_q;
    logic [ADDR_W-1:0] issue_cnt, wr_cnt;
    logic [CW-1:0]     inflight, fifo_cnt;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [DATA_W-1:0] fifo_mem [MAX_INFLIGHT];

    logic accept, issue, last_issue, last_wr, push, pop, fifo_full, push_ok;

    assign accept     = (state == IDLE) && start;
    assign issue      = (state == RUN) && (issue_cnt < len_q) && (inflight < CW'(MAX_INFLIGHT));
    assign last_issue = issue && (issue_cnt == len_q - ADDR_W'(1));
    assign pop        = dst_wen;
    assign last_wr    = pop && (wr_cnt == len_q - ADDR_W'(1));
    assign push       = pe_out_valid && ((state == RUN) || (state == DRAIN));
    assign fifo_full  = (fifo_cnt == CW'(MAX_INFLIGHT));
    // When full, a same-cycle pop frees the slot first.
    assign push_ok    = push && (!fifo_full || pop);

    assign src_ren    = issue;
    assign src_addr   = src_base_q + issue_cnt;
    assign pe_in_data = src_rdata;
    assign dst_req    = (fifo_cnt != '0);
    assign dst_wen    = dst_req && dst_gnt;
    assign dst_addr   = dst_base_q + wr_cnt;
    assign dst_wdata  = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? FIN : RUN;
            end
            RUN: begin
                busy     = 1'b1;
                err_busy = start;
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                err_busy = start;
                if (last_wr) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                err_busy  = start;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            wr_cnt      <= '0;
            inflight    <= '0;
            pe_in_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pe_in_valid <= src_ren;
            if (accept) begin
                src_base_q <= src_base;
                dst_base_q <= dst_base;
                len_q      <= len;
                issue_cnt  <= '0;
                wr_cnt     <= '0;
                inflight   <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + ADDR_W'(1);
                if (pop)   wr_cnt    <= wr_cnt + ADDR_W'(1);
                case ({issue, pop})
                    2'b10:   inflight <= inflight + CW'(1);
                    2'b01:   inflight <= inflight - CW'(1);
                    default: inflight <= inflight;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= pe_out_data;
    end

endmodule

// File: tb/tb_eltwise_stream_ctrl.sv
// Bench for eltwise_stream_ctrl: source SRAM and PE pipeline models, address/data scoreboard,
// a table of jobs plus hand-written timing, stall, zero-length, error and reset sequences.
module tb_eltwise_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  src_base, dst_base, len;
    logic        busy, done, err_busy, src_ren, pe_in_valid, dst_req, dst_gnt, dst_wen;
    logic [9:0]  src_addr, dst_addr;
    logic [15:0] src_rdata, pe_in_data, pe_out_data, dst_wdata;
    logic        pe_out_valid;

    eltwise_stream_ctrl #(.ADDR_W(10), .DATA_W(16), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .err_busy(err_busy), .src_ren(src_ren), .src_addr(src_addr),
        .src_rdata(src_rdata), .pe_in_valid(pe_in_valid), .pe_in_data(pe_in_data),
        .pe_out_valid(pe_out_valid), .pe_out_data(pe_out_data), .dst_req(dst_req),
        .dst_gnt(dst_gnt), .dst_wen(dst_wen), .dst_addr(dst_addr), .dst_wdata(dst_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int job_c = 0;
    int gnt_mode = 1;
    int pe_lat   = 1;

    logic [15:0] src_mem [1024];
    logic        v_pipe [8];
    logic [15:0] d_pipe [8];

    logic [9:0]  exp_src_q [$];
    logic [25:0] exp_dst_q [$];

    int n_src, n_wr, n_done, n_busy, n_err, max_infl, max_occ, occ, src_at19;
    int first_src_c, last_src_c, first_wr_c, last_wr_c, done_c, busy_first, busy_last;
    logic [9:0] first_src_a, last_src_a, first_wr_a, last_wr_a;

    typedef struct {
        logic [9:0] sb, db, ln;
        int         gmode, lat, err_at;
        logic [9:0] sf, sl, df, dl;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [15:0] relu(logic [15:0] x);
        return x[15] ? 16'h0000 : x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source SRAM: one-cycle read latency.
    always @(posedge clk or negedge rst) begin
        if (!rst) src_rdata <= '0;
        else if (src_ren) src_rdata <= src_mem[src_addr];
    end

    // PE model with selectable fixed latency.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                v_pipe[k] <= 1'b0;
                d_pipe[k] <= '0;
            end
        end else begin
            v_pipe[0] <= pe_in_valid;
            d_pipe[0] <= relu(pe_in_data);
            for (int k = 1; k < 8; k++) begin
                v_pipe[k] <= v_pipe[k-1];
                d_pipe[k] <= d_pipe[k-1];
            end
        end
    end
    assign pe_out_valid = v_pipe[pe_lat-1];
    assign pe_out_data  = d_pipe[pe_lat-1];

    initial begin
        dst_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       dst_gnt = 1'b0;
                1:       dst_gnt = 1'b1;
                2:       dst_gnt = 1'($urandom_range(0, 1));
                default: dst_gnt = ((cyc - job_c + 1) >= 20);
            endcase
        end
    end

    // Monitor: scoreboard pops, FIFO occupancy model and per-job statistics.
    always @(negedge clk) begin
        int  rel;
        bit  psh;
        if (!rst) begin
            occ = 0;
        end else begin
            rel = cyc - job_c + 1;
            if (src_ren) begin
                n_src++;
                if (n_src == 1) begin first_src_a = src_addr; first_src_c = rel; end
                last_src_a = src_addr; last_src_c = rel;
                if (exp_src_q.size() == 0) check("src_extra", 1, 0);
                else check("src_addr", src_addr, exp_src_q.pop_front());
            end
            if (dst_wen) begin
                n_wr++;
                if (n_wr == 1) begin first_wr_a = dst_addr; first_wr_c = rel; end
                last_wr_a = dst_addr; last_wr_c = rel;
                if (exp_dst_q.size() == 0) check("dst_extra", 1, 0);
                else check("dst_addr_data", {dst_addr, dst_wdata}, exp_dst_q.pop_front());
            end
            check("dst_req_vs_occ", dst_req, occ != 0);
            check("dst_wen_gate", dst_wen, dst_req & dst_gnt);
            if (done) begin n_done++; done_c = rel; end
            if (busy) begin
                n_busy++;
                if (n_busy == 1) busy_first = rel;
                busy_last = rel;
            end
            if (err_busy) n_err++;
            if (n_src - n_wr > max_infl) max_infl = n_src - n_wr;
            if (rel == 19) src_at19 = n_src;
            psh = pe_out_valid && busy;
            if (psh && occ == 4) check("fifo_overflow", dst_wen, 1);
            occ = occ + int'(psh) - int'(dst_wen);
            if (occ > max_occ) max_occ = occ;
        end
    end

    task automatic clear_stats();
        n_src = 0; n_wr = 0; n_done = 0; n_busy = 0; n_err = 0;
        max_infl = 0; max_occ = 0; src_at19 = -1;
        first_src_c = -1; last_src_c = -1; first_wr_c = -1; last_wr_c = -1;
        done_c = -1; busy_first = -1; busy_last = -1;
        exp_src_q.delete();
        exp_dst_q.delete();
    endtask

    task automatic load_expect(input logic [9:0] sb, input logic [9:0] db, input logic [9:0] ln);
        logic [9:0] sa, da;
        for (int i = 0; i < int'(ln); i++) begin
            sa = sb + 10'(i);
            da = db + 10'(i);
            exp_src_q.push_back(sa);
            exp_dst_q.push_back({da, relu(src_mem[sa])});
        end
    endtask

    task automatic start_job(input logic [9:0] sb, input logic [9:0] db, input logic [9:0] ln);
        @(posedge clk);
        #1;
        src_base = sb; dst_base = db; len = ln; start = 1'b1;
        @(posedge clk);
        #1;
        job_c = cyc;
        start = 1'b0;
    endtask

    task automatic run_job(input logic [9:0] sb, input logic [9:0] db, input logic [9:0] ln,
                           input int gm, input int lat, input int err_at);
        clear_stats();
        pe_lat   = lat;
        gnt_mode = gm;
        load_expect(sb, db, ln);
        start_job(sb, db, ln);
        for (int k = 1; k <= 20000 && n_done == 0; k++) begin
            @(posedge clk);
            #1;
            start = (k == err_at);
        end
        start = 1'b0;
        if (n_done == 0) check("done_timeout", 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("n_src", n_src, ln);
        check("n_wr", n_wr, ln);
        check("n_done", n_done, 1);
        check("src_q_left", exp_src_q.size(), 0);
        check("dst_q_left", exp_dst_q.size(), 0);
        check("inflight_le_4", max_infl <= 4, 1);
        check("n_err", n_err, err_at != 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
        for (int i = 0; i < 1024; i++) src_mem[i] = 16'($urandom);
        tbl[0] = '{10'h010, 10'h200, 10'd4,  1, 1, 0, 10'h010, 10'h013, 10'h200, 10'h203};
        tbl[1] = '{10'h3FE, 10'h3FF, 10'd3,  1, 2, 0, 10'h3FE, 10'h000, 10'h3FF, 10'h001};
        tbl[2] = '{10'h100, 10'h150, 10'd16, 2, 3, 5, 10'h100, 10'h10F, 10'h150, 10'h15F};
        tbl[3] = '{10'h000, 10'h3F0, 10'd20, 1, 3, 0, 10'h000, 10'h013, 10'h3F0, 10'h003};
        tbl[4] = '{10'h3F8, 10'h000, 10'd8,  2, 1, 3, 10'h3F8, 10'h3FF, 10'h000, 10'h007};
        clear_stats();
        occ = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, err_busy, src_ren, pe_in_valid, dst_req, dst_wen}, 7'b0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].sb, tbl[i].db, tbl[i].ln, tbl[i].gmode, tbl[i].lat, tbl[i].err_at);
            check("first_src", first_src_a, tbl[i].sf);
            check("last_src", last_src_a, tbl[i].sl);
            check("first_dst", first_wr_a, tbl[i].df);
            check("last_dst", last_wr_a, tbl[i].dl);
        end

        // Basic job cycle timing.
        run_job(10'h010, 10'h200, 10'd4, 1, 1, 0);
        check("basic_src_first_c", first_src_c, 1);
        check("basic_src_last_c", last_src_c, 4);
        check("basic_wr_first_c", first_wr_c, 4);
        check("basic_wr_last_c", last_wr_c, 7);
        check("basic_done_c", done_c, 8);
        check("basic_busy_first", busy_first, 1);
        check("basic_busy_last", busy_last, 7);
        check("basic_busy_cnt", n_busy, 7);

        // Zero length.
        run_job(10'h055, 10'h066, 10'd0, 1, 1, 0);
        check("zero_done_c", done_c, 1);
        check("zero_busy", n_busy, 0);

        // Grant stall until cycle 20.
        run_job(10'h020, 10'h300, 10'd8, 3, 1, 0);
        check("stall_src_at19", src_at19, 4);
        check("stall_max_occ", max_occ, 4);
        check("stall_first_wr_c", first_wr_c, 20);

        // Long job with random grant and PE latency 3.
        run_job(10'h001, 10'h002, 10'd1023, 2, 3, 0);
        check("long_max_infl", max_infl, 4);

        // Reset in the middle of DRAIN.
        clear_stats();
        pe_lat = 1;
        gnt_mode = 0;
        load_expect(10'h080, 10'h090, 10'd4);
        start_job(10'h080, 10'h090, 10'd4);
        repeat (8) @(posedge clk);
        #1;
        check("drain_busy", busy, 1);
        check("drain_src_cnt", n_src, 4);
        rst = 1'b0;
        #2;
        check("midreset_outputs", {busy, done, err_busy, src_ren, pe_in_valid, dst_req, dst_wen}, 7'b0);
        gnt_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_done", n_done, 0);
        check("midreset_no_wr", n_wr, 0);
        run_job(10'h0A0, 10'h0B0, 10'd2, 1, 2, 0);
        check("after_reset_first_dst", first_wr_a, 10'h0B0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
